// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: FSM state, next-PC select
// and the priority function that picks the next-PC source.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_SEQ  = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_RET  = 3'd3,
        SEL_BR   = 3'd4,
        SEL_EXC  = 3'd5
    } pc_sel_t;

    // Next-PC source in RUN; a halt without exc freezes the PC.
    function automatic pc_sel_t pc_select(input logic exc,
                                          input logic halt,
                                          input logic br_taken,
                                          input logic ret,
                                          input logic jmp,
                                          input logic advance);
        pc_sel_t sel;
        sel = SEL_HOLD;
        if (exc)           sel = SEL_EXC;
        else if (halt)     sel = SEL_HOLD;
        else if (br_taken) sel = SEL_BR;
        else if (ret)      sel = SEL_RET;
        else if (jmp)      sel = SEL_JMP;
        else if (advance)  sel = SEL_SEQ;
        return sel;
    endfunction

endpackage

// File: rtl/pc_if.sv
// Fetch-control bundle between the pipeline (master) and the PC unit (slave).
interface pc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic             imem_ready;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             jmp;
    logic [WIDTH-1:0] jmp_target;
    logic             call;
    logic             ret;
    logic             exc;
    logic             halt;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;

    modport master (
        output stall, imem_ready, br_taken, br_target, jmp, jmp_target,
               call, ret, exc, halt,
        input  pc, pc_valid
    );

    modport slave (
        input  stall, imem_ready, br_taken, br_target, jmp, jmp_target,
               call, ret, exc, halt,
        output pc, pc_valid
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry,
// and push+pop in one cycle replaces the top entry.
module pc_ras #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_push_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic             o_full
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_top_idx;
    logic             w_do_pop;

    assign w_top_idx = r_ptr - PW'(1);
    assign o_top     = r_mem[w_top_idx];
    assign o_empty   = (r_count == CW'(0));
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_push && !w_do_pop) begin
            r_ptr <= r_ptr + PW'(1);
            if (!o_full) r_count <= r_count + CW'(1);
        end else if (w_do_pop && !i_push) begin
            r_ptr   <= r_ptr - PW'(1);
            r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[w_do_pop ? w_top_idx : r_ptr] <= i_push_data;
    end
endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: BOOT/RUN/HALT FSM with prioritised redirects.
// Define PC_RAS_EN to predict ret targets with a return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      INC       = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'('h80),
    parameter int unsigned      RAS_DEPTH = 4
) (
    input logic  clk,
    input logic  reset,
    pc_if.slave  bus
);
    pc_state_t        r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_valid;
    pc_sel_t          w_sel;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_ret_target;

    assign bus.pc       = r_pc;
    assign bus.pc_valid = r_valid;
    assign w_sel = pc_select(bus.exc, bus.halt, bus.br_taken, bus.ret, bus.jmp,
                             bus.imem_ready & ~bus.stall);

`ifdef PC_RAS_EN
    logic             w_push;
    logic             w_pop;
    logic             w_ras_empty;
    logic             w_unused_ras_full;
    logic [WIDTH-1:0] w_ras_top;

    // A call pushes only when its own redirect (jmp, or a paired ret) wins.
    assign w_push = (r_state == RUN) && bus.call && (w_sel == SEL_JMP || w_sel == SEL_RET);
    assign w_pop  = (r_state == RUN) && (w_sel == SEL_RET);
    assign w_ret_target = w_ras_empty ? bus.jmp_target : w_ras_top;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (WIDTH'(r_pc + WIDTH'(INC))),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty),
        .o_full      (w_unused_ras_full)
    );
`else
    logic w_unused;

    assign w_ret_target = bus.jmp_target;
    assign w_unused     = ^{bus.call, 32'(RAS_DEPTH)};
`endif

    always_comb begin
        w_next = r_pc;
        case (w_sel)
            SEL_EXC: w_next = EXC_VEC;
            SEL_BR:  w_next = bus.br_target;
            SEL_RET: w_next = w_ret_target;
            SEL_JMP: w_next = bus.jmp_target;
            SEL_SEQ: w_next = WIDTH'(r_pc + WIDTH'(INC));
            default: w_next = r_pc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BOOT;
            r_pc    <= RESET_VEC;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state <= RUN;
                    r_valid <= 1'b1;
                end
                RUN: begin
                    r_pc <= w_next;
                    if (bus.halt && !bus.exc) begin
                        r_state <= HALT;
                        r_valid <= 1'b0;
                    end
                end
                HALT: begin
                    if (bus.exc) begin
                        r_pc    <= EXC_VEC;
                        r_state <= RUN;
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= BOOT;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
